// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a cascaded 2:1 mux tree: walks the select bus, samples each channel into a shadow and publishes whole frames.
// Optional continuous mode is compiled in with MUX_SCAN_CONT_EN (default build is one-shot).
module mux_scan_ctrl #(
  parameter  int unsigned WIDTH  = 1,
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned SETTLE = 2,
  localparam int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        mux_y,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH*WIDTH-1:0]   frame
);

  localparam int unsigned CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned FRAME_W = N_CH * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [FRAME_W-1:0]   r_shadow, w_shadow_nxt;
  logic [FRAME_W-1:0]   r_frame, w_frame_nxt;
  logic                 w_settled;
  logic                 w_last_ch;
  logic                 w_idle_go;
  logic                 w_done_go;
  logic                 r_arm, w_arm_nxt;

  assign w_settled = (r_cnt == CNT_W'(SETTLE - 1));
  assign w_last_ch = (r_sel == SEL_W'(N_CH - 1));

`ifdef MUX_SCAN_CONT_EN
  // Armed out of reset; an abort disarms until the next start.
  assign w_idle_go = start | r_arm;
  assign w_done_go = 1'b1;
`else
  assign w_idle_go = start;
  assign w_done_go = start & ~abort;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_arm    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_shadow <= w_shadow_nxt;
      r_frame  <= w_frame_nxt;
      r_arm    <= w_arm_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = r_frame;
    w_arm_nxt    = r_arm;

    case (r_state)
      S_IDLE: begin
        w_sel_nxt  = '0;
        w_cnt_nxt  = '0;
        w_busy_nxt = 1'b0;
`ifdef MUX_SCAN_CONT_EN
        if (start) begin
          w_arm_nxt = 1'b1;
        end
`endif
        if (w_idle_go) begin
          w_state_nxt = S_SCAN;
          w_busy_nxt  = 1'b1;
        end
      end

      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_arm_nxt   = 1'b0;
        end else if (w_settled) begin
          w_cnt_nxt = '0;
          for (int i = 0; i < int'(N_CH); i++) begin
            if (r_sel == SEL_W'(i)) begin
              w_shadow_nxt[i*WIDTH +: WIDTH] = mux_y;
            end
          end
          if (w_last_ch) begin
            // Frame picks up the final sample on the same edge it is taken.
            w_state_nxt = S_DONE;
            w_frame_nxt = w_shadow_nxt;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sel_nxt   = '0;
          end else begin
            w_sel_nxt = r_sel + SEL_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        w_sel_nxt = '0;
        w_cnt_nxt = '0;
        if (w_done_go) begin
          w_state_nxt = S_SCAN;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign sel   = r_sel;
  assign busy  = r_busy;
  assign done  = r_done;
  assign frame = r_frame;

endmodule
